// File: rtl/regfile_wb_arbiter_if.sv
// Write-back / operand-fetch bundle for the MIPS register file: two read ports,
// the primary pipeline write port and the valid/ready secondary write port.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              rs_pending;
    logic              rt_pending;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              aux_valid;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_data;
    logic              aux_ready;
    logic [CNT_W-1:0]  aux_count;

    modport master (
        output rs_addr, rt_addr, wb_we, wb_addr, wb_data, aux_valid, aux_addr, aux_data,
        input  rs_data, rt_data, rs_pending, rt_pending, aux_ready, aux_count
    );

    modport slave (
        input  rs_addr, rt_addr, wb_we, wb_addr, wb_data, aux_valid, aux_addr, aux_data,
        output rs_data, rt_data, rs_pending, rt_pending, aux_ready, aux_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// 32x32 MIPS register file whose write side merges the in-order write-back port
// with a FIFO of late secondary results that drain whenever the primary port is idle.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int NREGS = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_regs      [NREGS];
    logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_ready;

    logic              w_wb_hit;
    logic              w_push;
    logic              w_drain;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [1:0][ADDR_W-1:0] w_rd_addr;
    logic [1:0][DATA_W-1:0] w_rd_data;
    logic [1:0]             w_rd_pend;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // The secondary port may only use the array when the primary port is not writing.
    assign w_wb_hit    = bus.wb_we && (bus.wb_addr != '0);
    assign w_push      = bus.aux_valid && r_ready;
    assign w_drain     = (r_count != '0) && !w_wb_hit;
    assign w_head_addr = r_fifo_addr[r_head];
    assign w_head_data = r_fifo_data[r_head];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_drain) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_drain) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    assign w_rd_addr[0] = bus.rs_addr;
    assign w_rd_addr[1] = bus.rt_addr;

    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        w_rd_data = '0;
        w_rd_pend = '0;
        for (int p = 0; p < 2; p++) begin
            if (w_rd_addr[p] == '0) begin
                w_rd_data[p] = '0;
            end else if (w_wb_hit && (bus.wb_addr == w_rd_addr[p])) begin
                w_rd_data[p] = bus.wb_data;
            end else if (w_drain && (w_head_addr == w_rd_addr[p])) begin
                w_rd_data[p] = w_head_data;
            end else begin
                w_rd_data[p] = r_regs[w_rd_addr[p]];
            end
            // Walk the occupied slots from the head; a head leaving this cycle no longer blocks.
            idx = r_head;
            for (int k = 0; k < DEPTH; k++) begin
                if ((k < int'(r_count)) && !((k == 0) && w_drain) &&
                    (w_rd_addr[p] != '0) && (r_fifo_addr[idx] == w_rd_addr[p])) begin
                    w_rd_pend[p] = 1'b1;
                end
                idx = ptr_inc(idx);
            end
        end
    end

    assign bus.rs_data    = w_rd_data[0];
    assign bus.rt_data    = w_rd_data[1];
    assign bus.rs_pending = w_rd_pend[0];
    assign bus.rt_pending = w_rd_pend[1];
    assign bus.aux_ready  = r_ready;
    assign bus.aux_count  = r_count;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            if (w_wb_hit) begin
                r_regs[bus.wb_addr] <= bus.wb_data;
            end else if (w_drain && (w_head_addr != '0)) begin
                r_regs[w_head_addr] <= w_head_data;
            end
            if (w_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_drain) begin
                r_head <= ptr_inc(r_head);
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt < CNT_W'(DEPTH));
        end
    end

    // NOTE: the architectural registers must read 0 after reset, so they are cleared; the FIFO
    // payload is not, because r_count alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_tail] <= bus.aux_addr;
            r_fifo_data[r_tail] <= bus.aux_data;
        end
    end
endmodule
